// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   NIB_W  = 4;

  // Nibble index width; never narrower than one bit.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Host-side handshake and data bundle for the nibble-serial add/subtract unit.
interface nibble_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, co, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, co, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub_nibble_add.sv
// Combinational 4-bit ripple-carry slice built from per-bit full adders.
module nibble_add
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] c;

  assign c[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < NIB_W; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract that reuses one 4-bit slice per clock, LS nibble first,
// with a start/busy/done handshake toward the host.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_addsub_if.slave  bus
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               co_q, co_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   opa_nib [NIB];
  logic [NIB_W-1:0]   opb_nib [NIB];
  logic [NIB_W-1:0]   slice_s;
  logic               slice_co;
  logic [WIDTH-1:0]   result_wr;

  // Operand nibble views and the result with the current nibble replaced.
  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_nib
      assign opa_nib[gi] = opa_q[NIB_W*gi +: NIB_W];
      assign opb_nib[gi] = opb_q[NIB_W*gi +: NIB_W];
      assign result_wr[NIB_W*gi +: NIB_W] =
        (idx_q == IDX_W'(gi)) ? slice_s : result_q[NIB_W*gi +: NIB_W];
    end
  endgenerate

  nibble_add u_slice (
    .a  (opa_nib[idx_q]),
    .b  (opb_nib[idx_q]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    co_d     = co_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          state_d  = RUN;
          opa_d    = bus.a;
          opb_d    = (bus.op == OP_SUB) ? ~bus.b : bus.b;
          carry_d  = bus.op;
          idx_d    = '0;
          result_d = '0;
        end
      end
      RUN: begin
        result_d = result_wr;
        carry_d  = slice_co;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
          co_d    = slice_co;
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (slice_s[NIB_W-1] != opa_q[WIDTH-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.co     = co_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench: vector table plus handshake/reset sequences, results
// checked by a scoreboard monitor on every done pulse.
module tb_nibble_serial_addsub;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  nibble_serial_addsub_if #(.WIDTH(W)) bus();

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb    = o ? ~y : y;
    full  = {1'b0, x} + {1'b0, bb} + (W+1)'(o);
    e.r   = full[W-1:0];
    e.co  = full[W];
    e.ovf = (x[W-1] == bb[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest accepted operation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("busy_done_excl", {31'b0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {16'b0, bus.result}, {16'b0, e.r});
        chk("co", {31'b0, bus.co}, {31'b0, e.co});
        chk("ovf", {31'b0, bus.ovf}, {31'b0, e.ovf});
        $display("txn t=%0t result=%h co=%b ovf=%b (exp %h %b %b)",
                 $time, bus.result, bus.co, bus.ovf, e.r, e.co, e.ovf);
      end
    end
  end

  // Called on the negedge of the first RUN cycle; ends on the negedge of DONE.
  task automatic check_latency(input string tag);
    for (int i = 0; i < NIB; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      chk({tag, "_nodone"}, {31'b0, bus.done}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {31'b0, bus.done}, 32'd1);
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input exp_t e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check_latency("lat");
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    int   seen;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", {16'b0, bus.result}, 32'd0);
    chk("rst_co", {31'b0, bus.co}, 32'd0);
    chk("rst_ovf", {31'b0, bus.ovf}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      e.r   = vecs[i].r;
      e.co  = vecs[i].co;
      e.ovf = vecs[i].ovf;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 6; i++) begin
      logic         o;
      logic [W-1:0] x, y;
      o = 1'($urandom_range(0, 1));
      x = W'($urandom);
      y = W'($urandom);
      run_op(o, x, y, model(o, x, y));
    end

    // start pulsed mid-RUN with other operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h0FFF;
    @(posedge clk);
    sb.push_back(model(1'b0, 16'h1234, 16'h0FFF));
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_busy1", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555;
    chk("ign_busy2", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_busy3", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("ign_busy4", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("ign_done", {31'b0, bus.done}, 32'd1);
    @(negedge clk);
    chk("ign_idle_busy", {31'b0, bus.busy}, 32'd0);
    chk("ign_idle_done", {31'b0, bus.done}, 32'd0);

    // start held through DONE: back-to-back with no bubble
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222;
    @(posedge clk);
    sb.push_back(model(1'b0, 16'h1111, 16'h2222));
    @(negedge clk);
    bus.op = 1'b1; bus.a = 16'h0005; bus.b = 16'h0007;
    check_latency("b2b1");
    @(posedge clk);
    sb.push_back(model(1'b1, 16'h0005, 16'h0007));
    @(negedge clk);
    bus.start = 1'b0;
    check_latency("b2b2");

    // reset in the second RUN cycle discards the operation
    run_op(1'b1, 16'h8000, 16'h0001, model(1'b1, 16'h8000, 16'h0001));
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h0FFF;
    @(posedge clk);
    sb.push_back(model(1'b0, 16'h1234, 16'h0FFF));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mrst_done", {31'b0, bus.done}, 32'd0);
    chk("mrst_result", {16'b0, bus.result}, 32'd0);
    chk("mrst_co", {31'b0, bus.co}, 32'd0);
    chk("mrst_ovf", {31'b0, bus.ovf}, 32'd0);
    seen = 0;
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    chk("mrst_quiet", seen, 32'd0);
    run_op(1'b0, 16'h0F0F, 16'h00F1, model(1'b0, 16'h0F0F, 16'h00F1));

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle WIDTH-bit add/subtract unit that reuses one 4-bit ripple adder slice once per nibble, least significant nibble first.
- Sequences operand nibbles, carries between nibbles in a register and inverts B for subtraction.
- Gives the arithmetic path wide add/sub without a wide combinational carry chain.
- Handshake is start/busy/done toward a host controller.

Parameters:
- WIDTH, 16, operand and result width. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (derived, localparam), number of nibble iterations.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  1  0 = A+B, 1 = A-B; latched with start
- a  in  WIDTH  operand A; latched with start
- b  in  WIDTH  operand B; latched with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result/co/ovf valid
- result  out  WIDTH  sum/difference; held until next accepted start
- co  out  1  carry out of MSB nibble (subtract: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE, idx=0, carry reg=0, busy=0, done=0, result=0, co=0, ovf=0.
- Reset has priority over all other inputs, including mid-RUN. The partial result is discarded and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - latch a into opa, latch b (op=1: ~b) into opb, latch op;
  - carry reg = op; idx=0; result cleared to 0.
- RUN, each cycle:
  - slice adds opa[4*idx+:4], opb[4*idx+:4] and carry reg;
  - sum nibble written to result[4*idx+:4]; carry reg = slice carry out;
  - idx increments.
- RUN exits after the idx=NIB-1 cycle, to DONE:
  - co = final slice carry;
  - ovf = (opa[MSB]==opb[MSB]) && (sum MSB != opa[MSB]), computed on the inverted B for subtract.
- DONE lasts exactly one cycle with done=1.
  - start=1 in DONE: accepted as in IDLE, go to RUN (back-to-back, no bubble).
  - otherwise go to IDLE.
- Latency: start accepted at edge k; busy=1 for cycles k+1..k+NIB; done=1 for cycle k+NIB+1.
- Throughput is one operation per NIB+1 cycles.
- start while busy=1 is ignored (not queued). a/b/op changes during RUN have no effect.
- result, co and ovf hold their values in IDLE until the next accepted start.
- busy and done are never high together.
- Widths:
  - idx is clog2(NIB) bits, minimum 1.
  - Wrap-around is modulo 2^WIDTH; co carries the lost bit.
- WIDTH=4: a single RUN cycle.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, DONE);
  - localparams OP_ADD=0, OP_SUB=1;
  - NIB_W=4.
- One sub-module, nibble_add: combinational 4-bit slice with inputs a[3:0], b[3:0], ci and outputs s[3:0], co. It is built from per-bit full-adder logic with ripple carry.
- The controller FSM, operand registers, idx counter and carry register stay in nibble_serial_addsub.

Test Plan:
- WIDTH=16: start, op=0, a=0x1234, b=0x0FFF.
  - busy high 4 cycles, done on 5th cycle after start edge;
  - result=0x2233, co=0, ovf=0.
- op=0, a=0xFFFF, b=0x0001 -> result=0x0000, co=1, ovf=0.
- op=0, a=0x7FFF, b=0x0001 -> result=0x8000, co=0, ovf=1.
- Subtract cases:
  - op=1, a=0x0005, b=0x0007 -> result=0xFFFE, co=0, ovf=0;
  - op=1, a=0x8000, b=0x0001 -> result=0x7FFF, co=1, ovf=1.
- Handshake:
  - start pulsed during RUN with other operands -> ignored, first result unchanged;
  - start held during DONE -> new RUN begins next cycle, second done 5 cycles later.
- rst=1 in 2nd RUN cycle -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent start then completes normally.
